ext_int_controller: RTL and testbench
=====================================

Name: ext_int_controller

Overview:
- Multiplexes up to NUM_SRC external interrupt sources onto the CPU's single external-interrupt line.
- Per source: edge detection, pending latching, masking and priority arbitration.
- Presents one request at a time plus a 1-based source id; the CPU reads the id in its shared external-interrupt handler.
- Sits between peripherals and the PC/interrupt logic; sequences one interrupt through request, acknowledge and service (ended by reti).

Parameters:
- NUM_SRC, 8: number of external interrupt sources (1..255).
- ID_W, 8: width of int_id.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- src  in  NUM_SRC  raw interrupt lines, rising-edge triggered, synchronous to clk
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NUM_SRC  new mask value; bit=1 masks the source
- mask_out  out  NUM_SRC  current mask register
- pending_out  out  NUM_SRC  current pending register
- int_req  out  1  interrupt request to CPU; level, held until int_ack
- int_id  out  ID_W  1-based id of granted source (index+1); 0 after reset
- int_ack  in  1  one-cycle pulse: CPU has taken the interrupt vector
- reti  in  1  one-cycle pulse: CPU executed return-from-interrupt

Behaviour:
- Reset values: int_req=0, int_id=0, mask=all ones, pending=0, src_prev=0, state=IDLE, rr_ptr=NUM_SRC-1.
- Since src_prev resets to 0, a src held high through reset release gives exactly one event.
- Edge detect: src_prev<=src every cycle. Rising edge (src & ~src_prev) sets the pending bit on the next clock.
- Masked sources still latch pending; they are only ineligible for arbitration.
- Eligible vector: pending & ~mask.
- Fixed priority: lowest index wins.

FSM:
- IDLE:
  - If eligible != 0: latch winner index, int_id<=winner+1, int_req<=1, go REQ (registered, one cycle).
  - Else stay.
- REQ:
  - int_req and int_id held stable regardless of mask writes or new edges; a granted request is never withdrawn.
  - On int_ack: int_req<=0, clear pending[winner], go SERVICE.
- SERVICE:
  - No new request issued (CPU does not nest).
  - On reti: go IDLE. A new request can assert on the next cycle, giving one idle cycle minimum between reti and the next int_req.

Latency and timing:
- Edge on src sampled at cycle N: pending set at N+1, int_req high at N+2 if the block is IDLE and the source is unmasked.

Simultaneous events:
- New edge on the winner in the same cycle its pending is cleared: set wins, so the event is retained.
- mask_we in the same cycle as an IDLE grant decision: arbitration uses the old mask; the new mask takes effect next cycle.
- int_ack outside REQ and reti outside SERVICE: ignored.
- int_ack and reti in the same cycle while in REQ: ack processed, reti ignored.

Other rules:
- int_id keeps its last value after ack until the next grant.
- Mid-operation reset: all state returns to reset values immediately; pending events are lost.

Optional Feature:
- Macro: EXT_INT_CTRL_ROUNDROBIN_EN
- Defined: round-robin arbitration.
  - Search starts at index rr_ptr+1 with wrap-around modulo NUM_SRC.
  - rr_ptr<=winner when int_ack is accepted.
  - rr_ptr resets to NUM_SRC-1, so the first search starts at index 0.
- Undefined: fixed priority, lowest index wins; no rr_ptr register is synthesized.

Test Plan:
- Reset, mask=0x00, pulse src[3] one cycle at cycle 10: pending_out=0x08 at 11, int_req=1 with int_id=4 at 12; int_ack at 15 gives int_req=0 and pending_out=0x00 at 16.
- mask=0x00, src[5] and src[1] rise in the same cycle: int_id=2 first. After ack plus reti, int_id=6 is requested with pending_out=0x20 before its ack.
- mask=0xFF, edge on src[0]: pending_out=0x01, int_req stays 0. Write mask=0xFE: int_req=1, int_id=1 two cycles after the write.
- In SERVICE, edge on src[2]: no int_req until reti. reti at cycle T gives int_req=1, int_id=3 at T+2.
- src[4] rises in the same cycle as int_ack for granted source 5 (id 5): pending_out bit 4 set next cycle. Reset asserted in REQ: int_req=0, int_id=0, mask_out=0xFF next cycle.
- EXT_INT_CTRL_ROUNDROBIN_EN defined, mask=0x00, src[0] and src[1] re-pulsed after every reti: grants alternate id 1, 2, 1, 2. Undefined: id 1 on every grant.

Source files
------------

// File: rtl/ext_int_controller.sv
// External interrupt controller: per-source edge detect, pending latch, mask and arbitration
// onto a single request line. Define EXT_INT_CTRL_ROUNDROBIN_EN for round-robin arbitration.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; grant the next eligible source
// REQ     | int_req high with int_id held until the CPU acknowledges
// SERVICE | CPU is running the handler; wait for reti, no nesting
module ext_int_controller #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask_out,
   output logic [NUM_SRC-1:0] pending_out,
   output logic               int_req,
   output logic [ID_W-1:0]    int_id,
   input  logic               int_ack,
   input  logic               reti
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] pending, pending_nxt;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr;
   logic [IDX_W-1:0]   winner, winner_nxt;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_vld;
   logic               int_req_nxt;
   logic [ID_W-1:0]    int_id_nxt;

   assign eligible    = pending & ~mask;
   // a new edge on the source being cleared wins, so the event is not lost
   assign pending_nxt = (pending & ~clr) | (src & ~src_prev);
   assign mask_out    = mask;
   assign pending_out = pending;

`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   int               rr_idx;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rr_idx = (int'(rr_ptr) + 1 + i) % NUM_SRC;
         if (!grant_vld && eligible[IDX_W'(rr_idx)]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(rr_idx);
         end
      end
   end
`else
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      state_nxt   = state;
      int_req_nxt = int_req;
      int_id_nxt  = int_id;
      winner_nxt  = winner;
      clr         = '0;
`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
      rr_ptr_nxt  = rr_ptr;
`endif
      case (state)
         IDLE: begin
            if (grant_vld) begin
               winner_nxt  = grant_idx;
               int_id_nxt  = ID_W'(grant_idx) + ID_W'(1);
               int_req_nxt = 1'b1;
               state_nxt   = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               int_req_nxt = 1'b0;
               clr[winner] = 1'b1;
               state_nxt   = SERVICE;
`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
               rr_ptr_nxt  = winner;
`endif
            end
         end
         SERVICE: begin
            if (reti) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         src_prev <= '0;
         pending  <= '0;
         mask     <= '1;
         winner   <= '0;
         int_req  <= 1'b0;
         int_id   <= '0;
`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
         rr_ptr   <= IDX_W'(NUM_SRC - 1);
`endif
      end else begin
         state    <= state_nxt;
         src_prev <= src;
         pending  <= pending_nxt;
         if (mask_we) mask <= mask_wdata;
         winner   <= winner_nxt;
         int_req  <= int_req_nxt;
         int_id   <= int_id_nxt;
`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
         rr_ptr   <= rr_ptr_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_ext_int_controller.sv
// Scoreboard bench for ext_int_controller: expected grants (id and cycle) are queued by the
// stimulus; a monitor pops one on every rising int_req. Point checks cover pending/mask/reset.
module tb_ext_int_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] src;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] mask_out;
   logic [7:0] pending_out;
   logic       int_req;
   logic [7:0] int_id;
   logic       int_ack;
   logic       reti;

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic req_q   = 1'b0;

   ext_int_controller #(.NUM_SRC(8), .ID_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .src         (src),
      .mask_we     (mask_we),
      .mask_wdata  (mask_wdata),
      .mask_out    (mask_out),
      .pending_out (pending_out),
      .int_req     (int_req),
      .int_id      (int_id),
      .int_ack     (int_ack),
      .reti        (reti)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every new request must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (int_req && !req_q) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_grant: got id=%0d at cycle %0d, none expected", int_id, cyc);
         end else begin
            e = exp_q.pop_front();
            if (int_id !== 8'(e.id) || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL grant: got id=%0d at cycle %0d, expected id=%0d at cycle %0d",
                        int_id, cyc, e.id, e.cyc);
            end
         end
      end
      req_q = int_req;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // expected grant lands two clocks after the stimulus driven at this negedge
   task automatic push(input int id);
      exp_t e;
      e.id  = id;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
   endtask

   task automatic set_mask(input logic [7:0] m);
      mask_we = 1'b1; mask_wdata = m;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic pulse_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   function automatic int rr_id(input int j);
`ifdef EXT_INT_CTRL_ROUNDROBIN_EN
      return (j % 2 == 0) ? 1 : 2;
`else
      return 1;
`endif
   endfunction

   initial begin
      reset = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; reti = 1'b0;
      tick(2);
      chk("rst_int_req", 32'(int_req), 32'h0);
      chk("rst_int_id", 32'(int_id), 32'h0);
      chk("rst_mask", 32'(mask_out), 32'hFF);
      chk("rst_pending", 32'(pending_out), 32'h0);
      reset = 1'b0;
      tick();

      // single source, basic latency and ack
      set_mask(8'h00);
      chk("mask_write", 32'(mask_out), 32'h00);
      src = 8'h08; push(4);
      tick();
      src = 8'h00;
      chk("t1_pending", 32'(pending_out), 32'h08);
      chk("t1_req_early", 32'(int_req), 32'h0);
      tick();
      chk("t1_req", 32'(int_req), 32'h1);
      chk("t1_id", 32'(int_id), 32'h4);
      tick(2);
      chk("t1_req_held", 32'(int_req), 32'h1);
      pulse_ack();
      chk("t1_req_after_ack", 32'(int_req), 32'h0);
      chk("t1_pending_after_ack", 32'(pending_out), 32'h00);
      chk("t1_id_kept", 32'(int_id), 32'h4);
      pulse_reti();
      tick();

      // two simultaneous edges: lowest index first
      src = 8'h22; push(2);
      tick();
      src = 8'h00;
      chk("t2_pending", 32'(pending_out), 32'h22);
      tick();
      pulse_ack();
      chk("t2_pending_ack", 32'(pending_out), 32'h20);
      push(6);
      pulse_reti();
      tick();
      chk("t2_req2", 32'(int_req), 32'h1);
      chk("t2_pending2", 32'(pending_out), 32'h20);
      pulse_ack();
      pulse_reti();
      chk("t2_pending_end", 32'(pending_out), 32'h00);

      // masked source latches pending but is not granted
      set_mask(8'hFF);
      src = 8'h01;
      tick();
      src = 8'h00;
      chk("t3_pending_masked", 32'(pending_out), 32'h01);
      tick(3);
      chk("t3_no_req_masked", 32'(int_req), 32'h0);
      push(1);
      set_mask(8'hFE);
      tick();
      chk("t3_req_unmasked", 32'(int_req), 32'h1);
      pulse_ack();
      pulse_reti();

      // edge during SERVICE waits for reti
      set_mask(8'h00);
      src = 8'h40; push(7);
      tick();
      src = 8'h00;
      tick();
      pulse_ack();
      src = 8'h04;
      tick();
      src = 8'h00;
      tick(3);
      chk("t4_no_req_service", 32'(int_req), 32'h0);
      chk("t4_pending", 32'(pending_out), 32'h04);
      push(3);
      pulse_reti();
      chk("t4_idle_gap", 32'(int_req), 32'h0);
      tick();
      chk("t4_req_after_reti", 32'(int_req), 32'h1);
      chk("t4_id", 32'(int_id), 32'h3);
      pulse_ack();
      pulse_reti();

      // new edge on winner coincident with its ack; ack+reti together; reset in REQ
      src = 8'h10; push(5);
      tick();
      src = 8'h00;
      tick();
      int_ack = 1'b1; src = 8'h10;
      tick();
      int_ack = 1'b0; src = 8'h00;
      chk("t5_set_wins", 32'(pending_out), 32'h10);
      chk("t5_req_dropped", 32'(int_req), 32'h0);
      push(5);
      pulse_reti();
      tick();
      src = 8'h01;
      tick();
      src = 8'h00;
      chk("t5_id_stable", 32'(int_id), 32'h5);
      chk("t5_pending_req", 32'(pending_out), 32'h11);
      int_ack = 1'b1; reti = 1'b1;
      tick();
      int_ack = 1'b0; reti = 1'b0;
      chk("t5_ack_with_reti", 32'(int_req), 32'h0);
      tick(3);
      chk("t5_reti_ignored", 32'(int_req), 32'h0);
      push(1);
      pulse_reti();
      tick();
      set_mask(8'hFF);
      chk("t5_not_withdrawn", 32'(int_req), 32'h1);
      chk("t5_id_held", 32'(int_id), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_req", 32'(int_req), 32'h0);
      chk("t5_rst_id", 32'(int_id), 32'h0);
      chk("t5_rst_mask", 32'(mask_out), 32'hFF);
      chk("t5_rst_pending", 32'(pending_out), 32'h00);

      // mask write during the grant decision: old mask still applies
      set_mask(8'h00);
      src = 8'h02; push(2);
      tick();
      src = 8'h00;
      set_mask(8'hFF);
      chk("t6_old_mask_grant", 32'(int_req), 32'h1);
      chk("t6_new_mask", 32'(mask_out), 32'hFF);
      pulse_ack();
      pulse_reti();

      // arbitration order with two competing sources re-pulsed after each reti
      set_mask(8'h00);
      src = 8'h03; push(rr_id(0));
      tick();
      src = 8'h00;
      tick();
      for (int k = 0; k < 4; k++) begin
         pulse_ack();
         reti = 1'b1; src = 8'h03; push(rr_id(k + 1));
         tick();
         reti = 1'b0; src = 8'h00;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick(3);

      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_grant: got no request, expected id=%0d at cycle %0d", e.id, e.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
